// File: rtl/lsu_pkg.sv
// Shared types for the LSU memory-access stage: FSM states, error codes and the latched op.
package lsu_pkg;

  localparam int unsigned LsuAddrW   = 32;
  localparam int unsigned LsuDataW   = 32;
  localparam int unsigned LsuRegIdxW = 5;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2
  } lsu_mem_state_e;

  typedef enum logic [1:0] {
    ErrNone     = 2'd0,
    ErrMisalign = 2'd1,
    ErrIllegal  = 2'd2,
    ErrTimeout  = 2'd3
  } lsu_err_e;

  typedef struct packed {
    logic                  we;
    logic [LsuAddrW-1:0]   addr;
    logic [LsuDataW-1:0]   wdata;
    logic [LsuRegIdxW-1:0] rd_dest;
  } lsu_mem_op_t;

endpackage

// File: rtl/lsu_mem_access.sv
// LSU memory-access stage: issues one word load/store on a req/gnt + rvalid port,
// stalls execute while busy and reports load results or errors with one-cycle pulses.
module lsu_mem_access
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W    = LsuAddrW,
  parameter int unsigned DATA_W    = LsuDataW,
  parameter int unsigned REG_IDX_W = LsuRegIdxW,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ex_valid,
  input  logic                 ex_rd_en,
  input  logic [ADDR_W-1:0]    ex_rd_addr,
  input  logic                 ex_wr_en,
  input  logic [ADDR_W-1:0]    ex_wr_addr,
  input  logic [DATA_W-1:0]    ex_wr_data,
  input  logic [REG_IDX_W-1:0] ex_rd_dest,
  output logic                 ex_stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  input  logic                 mem_gnt,
  input  logic                 mem_rvalid,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 wb_valid,
  output logic [REG_IDX_W-1:0] wb_rd_dest,
  output logic [DATA_W-1:0]    wb_data,
  output logic                 err_valid,
  output logic [1:0]           err_code
);

  localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  lsu_mem_state_e        r_state;
  lsu_mem_state_e        w_state_d;
  lsu_mem_op_t           r_op;
  logic [CntW-1:0]       r_cnt;
  logic                  r_wb_valid;
  logic [REG_IDX_W-1:0]  r_wb_dest;
  logic [DATA_W-1:0]     r_wb_data;
  logic                  r_err_valid;
  lsu_err_e              r_err_code;

  logic                  w_accept;
  logic                  w_latch_op;
  logic                  w_cnt_clr;
  logic                  w_cnt_inc;
  logic                  w_wb_set;
  logic                  w_err_set;
  lsu_err_e              w_err_type;
  logic [ADDR_W-1:0]     w_sel_addr;

  assign w_accept   = ex_valid & (ex_rd_en | ex_wr_en);
  assign w_sel_addr = ex_rd_en ? ex_rd_addr : ex_wr_addr;

  always_comb begin
    w_state_d  = r_state;
    w_latch_op = 1'b0;
    w_cnt_clr  = 1'b0;
    w_cnt_inc  = 1'b0;
    w_wb_set   = 1'b0;
    w_err_set  = 1'b0;
    w_err_type = ErrNone;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (ex_rd_en && ex_wr_en) begin
            w_err_set  = 1'b1;
            w_err_type = ErrIllegal;
          end else if (w_sel_addr[1:0] != 2'b00) begin
            w_err_set  = 1'b1;
            w_err_type = ErrMisalign;
          end else begin
            w_latch_op = 1'b1;
            w_state_d  = StReq;
          end
        end
      end
      StReq: begin
        if (mem_gnt) begin
          if (r_op.we) begin
            w_state_d = StIdle;
          end else begin
            w_cnt_clr = 1'b1;
            w_state_d = StWait;
          end
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          w_wb_set  = 1'b1;
          w_state_d = StIdle;
        end else if (r_cnt == CntLast) begin
          w_err_set  = 1'b1;
          w_err_type = ErrTimeout;
          w_state_d  = StIdle;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op        <= '0;
      r_cnt       <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_dest   <= '0;
      r_wb_data   <= '0;
      r_err_valid <= 1'b0;
      r_err_code  <= ErrNone;
    end else begin
      r_state     <= w_state_d;
      r_wb_valid  <= w_wb_set;
      r_err_valid <= w_err_set;
      if (w_latch_op) begin
        r_op.we      <= ex_wr_en;
        r_op.addr    <= w_sel_addr;
        r_op.wdata   <= ex_wr_data;
        r_op.rd_dest <= ex_rd_dest;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_wb_set) begin
        r_wb_dest <= r_op.rd_dest;
        r_wb_data <= mem_rdata;
      end
      if (w_err_set) begin
        r_err_code <= w_err_type;
      end
    end
  end

  assign ex_stall   = (r_state != StIdle);
  assign mem_req    = (r_state == StReq);
  assign mem_we     = r_op.we;
  assign mem_addr   = r_op.addr;
  assign mem_wdata  = r_op.wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd_dest = r_wb_dest;
  assign wb_data    = r_wb_data;
  assign err_valid  = r_err_valid;
  assign err_code   = r_err_code;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed self-checking bench for lsu_mem_access.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_rd_en;
  logic [31:0] ex_rd_addr;
  logic        ex_wr_en;
  logic [31:0] ex_wr_addr;
  logic [31:0] ex_wr_data;
  logic [4:0]  ex_rd_dest;
  logic        ex_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd_dest;
  logic [31:0] wb_data;
  logic        err_valid;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_mem_access #(
    .ADDR_W   (32),
    .DATA_W   (32),
    .REG_IDX_W(5),
    .TIMEOUT  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_rd_en  (ex_rd_en),
    .ex_rd_addr(ex_rd_addr),
    .ex_wr_en  (ex_wr_en),
    .ex_wr_addr(ex_wr_addr),
    .ex_wr_data(ex_wr_data),
    .ex_rd_dest(ex_rd_dest),
    .ex_stall  (ex_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata),
    .wb_valid  (wb_valid),
    .wb_rd_dest(wb_rd_dest),
    .wb_data   (wb_data),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid   = 1'b0;
    ex_rd_en   = 1'b0;
    ex_wr_en   = 1'b0;
    ex_rd_addr = '0;
    ex_wr_addr = '0;
    ex_wr_data = '0;
    ex_rd_dest = '0;
  endtask

  task automatic drive_load(input logic [31:0] addr, input logic [4:0] dest);
    ex_valid   = 1'b1;
    ex_rd_en   = 1'b1;
    ex_wr_en   = 1'b0;
    ex_rd_addr = addr;
    ex_rd_dest = dest;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'd0, ex_stall}, 32'd0);
    chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    chk({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_addr"}, mem_addr, 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    chk({tag, "_wbd"}, {27'd0, wb_rd_dest}, 32'd0);
    chk({tag, "_wbdata"}, wb_data, 32'd0);
    chk({tag, "_errv"}, {31'd0, err_valid}, 32'd0);
    chk({tag, "_errc"}, {30'd0, err_code}, 32'd0);
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    drive_idle();
    step();
    step();
    chk_all_zero("rst");
    rst_n = 1'b1;

    // 1: best-case load
    drive_load(32'h100, 5'd5);
    chk("t1_accept_stall", {31'd0, ex_stall}, 32'd0);
    step();
    drive_idle();
    chk("t1_req", {31'd0, mem_req}, 32'd1);
    chk("t1_we", {31'd0, mem_we}, 32'd0);
    chk("t1_addr", mem_addr, 32'h100);
    chk("t1_stall_n1", {31'd0, ex_stall}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t1_req_wait", {31'd0, mem_req}, 32'd0);
    chk("t1_stall_n2", {31'd0, ex_stall}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hDEADBEEF;
    step();
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    chk("t1_wbv", {31'd0, wb_valid}, 32'd1);
    chk("t1_wbdest", {27'd0, wb_rd_dest}, 32'd5);
    chk("t1_wbdata", wb_data, 32'hDEADBEEF);
    chk("t1_stall_n3", {31'd0, ex_stall}, 32'd0);
    step();
    chk("t1_wbv_pulse", {31'd0, wb_valid}, 32'd0);
    chk("t1_wbdata_hold", wb_data, 32'hDEADBEEF);

    // 2: store with grant held off 3 cycles
    ex_valid   = 1'b1;
    ex_wr_en   = 1'b1;
    ex_wr_addr = 32'h200;
    ex_wr_data = 32'h12345678;
    step();
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      chk("t2_req", {31'd0, mem_req}, 32'd1);
      chk("t2_we", {31'd0, mem_we}, 32'd1);
      chk("t2_addr", mem_addr, 32'h200);
      chk("t2_wdata", mem_wdata, 32'h12345678);
      chk("t2_stall", {31'd0, ex_stall}, 32'd1);
      if (i == 3) mem_gnt = 1'b1;
      step();
    end
    mem_gnt = 1'b0;
    chk("t2_idle", {31'd0, ex_stall}, 32'd0);
    chk("t2_req_off", {31'd0, mem_req}, 32'd0);
    chk("t2_no_wb", {31'd0, wb_valid}, 32'd0);

    // 3: misaligned load
    drive_load(32'h102, 5'd6);
    step();
    drive_idle();
    chk("t3_errv", {31'd0, err_valid}, 32'd1);
    chk("t3_errc", {30'd0, err_code}, 32'd1);
    chk("t3_req", {31'd0, mem_req}, 32'd0);
    chk("t3_stall", {31'd0, ex_stall}, 32'd0);
    step();
    chk("t3_errv_pulse", {31'd0, err_valid}, 32'd0);
    chk("t3_errc_hold", {30'd0, err_code}, 32'd1);
    chk("t3_stall2", {31'd0, ex_stall}, 32'd0);

    // 4: both enables -> illegal; then a NOP
    ex_valid   = 1'b1;
    ex_rd_en   = 1'b1;
    ex_wr_en   = 1'b1;
    ex_rd_addr = 32'h300;
    ex_wr_addr = 32'h300;
    step();
    drive_idle();
    chk("t4_errv", {31'd0, err_valid}, 32'd1);
    chk("t4_errc", {30'd0, err_code}, 32'd2);
    chk("t4_req", {31'd0, mem_req}, 32'd0);
    ex_valid = 1'b1;
    step();
    drive_idle();
    chk("t4_nop_stall", {31'd0, ex_stall}, 32'd0);
    chk("t4_nop_req", {31'd0, mem_req}, 32'd0);
    chk("t4_nop_errv", {31'd0, err_valid}, 32'd0);
    chk("t4_nop_errc", {30'd0, err_code}, 32'd2);

    // 5: load timeout after 16 WAIT cycles, late rvalid ignored
    drive_load(32'h340, 5'd7);
    step();
    drive_idle();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("t5_wait_stall", {31'd0, ex_stall}, 32'd1);
      chk("t5_wait_errv", {31'd0, err_valid}, 32'd0);
      step();
    end
    chk("t5_last_wait", {31'd0, ex_stall}, 32'd1);
    step();
    chk("t5_errv", {31'd0, err_valid}, 32'd1);
    chk("t5_errc", {30'd0, err_code}, 32'd3);
    chk("t5_stall", {31'd0, ex_stall}, 32'd0);
    chk("t5_no_wb", {31'd0, wb_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBAD0BAD0;
    step();
    mem_rvalid = 1'b0;
    chk("t5_late_wbv", {31'd0, wb_valid}, 32'd0);
    chk("t5_late_wbdata", wb_data, 32'hDEADBEEF);
    chk("t5_late_stall", {31'd0, ex_stall}, 32'd0);

    // 6: reset during WAIT, rvalid after release ignored, then normal load
    drive_load(32'h400, 5'd9);
    step();
    drive_idle();
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    chk("t6_in_wait", {31'd0, ex_stall}, 32'd1);
    rst_n = 1'b0;
    step();
    chk_all_zero("t6_rst");
    rst_n = 1'b1;
    step();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0BADF00D;
    step();
    mem_rvalid = 1'b0;
    chk("t6_late_wbv", {31'd0, wb_valid}, 32'd0);
    chk("t6_late_stall", {31'd0, ex_stall}, 32'd0);
    drive_load(32'h500, 5'd3);
    step();
    drive_idle();
    chk("t6_req", {31'd0, mem_req}, 32'd1);
    chk("t6_addr", mem_addr, 32'h500);
    // rvalid coinciding with gnt must not complete the load
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h11111111;
    step();
    mem_gnt   = 1'b0;
    mem_rdata = 32'hCAFEF00D;
    chk("t6_gnt_rv_wbv", {31'd0, wb_valid}, 32'd0);
    chk("t6_wait_stall", {31'd0, ex_stall}, 32'd1);
    step();
    mem_rvalid = 1'b0;
    chk("t6_wbv", {31'd0, wb_valid}, 32'd1);
    chk("t6_wbdest", {27'd0, wb_rd_dest}, 32'd3);
    chk("t6_wbdata", wb_data, 32'hCAFEF00D);
    chk("t6_errc_cleared", {30'd0, err_code}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
